// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types for the receive-side frame filter.
package eth_pkg;

  typedef logic [47:0] mac_addr_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam mac_addr_t   MAC_BROADCAST  = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/eth_rx_frame_filter.sv
// Per-frame forward/drop decision on destination MAC and EtherType, with
// zero-latency payload pass-through and saturating pass/drop counters.
module eth_rx_frame_filter
  import eth_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned KEEP_ENABLE        = 0,
  parameter int unsigned TYPE_FILTER_ENABLE = 1,
  parameter int unsigned CNT_WIDTH          = 32
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    eth_header_in_valid,
  output logic                    eth_header_in_ready,
  input  mac_addr_t               eth_header_in_dest_mac,
  input  mac_addr_t               eth_header_in_src_mac,
  input  logic [15:0]             eth_header_in_eth_type,

  input  logic [DATA_WIDTH-1:0]   eth_payload_in_tdata,
  input  logic [DATA_WIDTH/8-1:0] eth_payload_in_tkeep,
  input  logic                    eth_payload_in_tvalid,
  output logic                    eth_payload_in_tready,
  input  logic                    eth_payload_in_tlast,
  input  logic                    eth_payload_in_tuser,

  output logic                    eth_header_out_valid,
  input  logic                    eth_header_out_ready,
  output mac_addr_t               eth_header_out_dest_mac,
  output mac_addr_t               eth_header_out_src_mac,
  output logic [15:0]             eth_header_out_eth_type,

  output logic [DATA_WIDTH-1:0]   eth_payload_out_tdata,
  output logic [DATA_WIDTH/8-1:0] eth_payload_out_tkeep,
  output logic                    eth_payload_out_tvalid,
  input  logic                    eth_payload_out_tready,
  output logic                    eth_payload_out_tlast,
  output logic                    eth_payload_out_tuser,

  input  mac_addr_t               cfg_local_mac,
  input  logic                    cfg_mcast_enable,
  output logic [CNT_WIDTH-1:0]    pass_count,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        hdr_ready_q, hdr_ready_d;
  mac_addr_t   dst_q, dst_d;
  mac_addr_t   src_q, src_d;
  logic [15:0] type_q, type_d;

  logic mac_ok;
  logic type_ok;
  logic frame_pass;
  logic hdr_accept;
  logic out_hdr_taken;

  always_comb begin
    mac_ok  = (eth_header_in_dest_mac == cfg_local_mac) ||
              (eth_header_in_dest_mac == MAC_BROADCAST) ||
              (cfg_mcast_enable && eth_header_in_dest_mac[40]);
    type_ok = (TYPE_FILTER_ENABLE == 0) ||
              (eth_header_in_eth_type == ETHERTYPE_IPV4) ||
              (eth_header_in_eth_type == ETHERTYPE_ARP);
    frame_pass = mac_ok && type_ok;
  end

  assign hdr_accept    = eth_header_in_valid && hdr_ready_q;
  assign out_hdr_taken = hdr_valid_q && eth_header_out_ready;

  always_comb begin
    state_d                = state_q;
    eth_payload_in_tready  = 1'b0;
    eth_payload_out_tvalid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hdr_accept) begin
          state_d = frame_pass ? PASS : DROP;
        end
      end
      PASS: begin
        eth_payload_out_tvalid = eth_payload_in_tvalid;
        eth_payload_in_tready  = eth_payload_out_tready;
        if (eth_payload_in_tvalid && eth_payload_out_tready && eth_payload_in_tlast) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        eth_payload_in_tready = 1'b1;
        if (eth_payload_in_tvalid && eth_payload_in_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Header ready is registered from next-state so it reads low during reset
  // yet still asserts on the cycle right after a tlast handshake.
  always_comb begin
    hdr_valid_d = hdr_valid_q;
    dst_d       = dst_q;
    src_d       = src_q;
    type_d      = type_q;
    if (out_hdr_taken) begin
      hdr_valid_d = 1'b0;
    end
    if (hdr_accept && frame_pass) begin
      hdr_valid_d = 1'b1;
      dst_d       = eth_header_in_dest_mac;
      src_d       = eth_header_in_src_mac;
      type_d      = eth_header_in_eth_type;
    end
    hdr_ready_d = (state_d == IDLE) && !hdr_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hdr_valid_q <= 1'b0;
      hdr_ready_q <= 1'b0;
      dst_q       <= '0;
      src_q       <= '0;
      type_q      <= '0;
    end else begin
      state_q     <= state_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_ready_q <= hdr_ready_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      type_q      <= type_d;
    end
  end

  assign eth_header_in_ready     = hdr_ready_q;
  assign eth_header_out_valid    = hdr_valid_q;
  assign eth_header_out_dest_mac = dst_q;
  assign eth_header_out_src_mac  = src_q;
  assign eth_header_out_eth_type = type_q;

  assign eth_payload_out_tdata = eth_payload_in_tdata;
  assign eth_payload_out_tkeep = (KEEP_ENABLE != 0) ? eth_payload_in_tkeep : '1;
  assign eth_payload_out_tlast = eth_payload_in_tlast;
  assign eth_payload_out_tuser = eth_payload_in_tuser;

  assign busy = (state_q != IDLE);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pass_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (hdr_accept && frame_pass),
    .clear_i (1'b0),
    .count_o (pass_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (hdr_accept && !frame_pass),
    .clear_i (1'b0),
    .count_o (drop_count)
  );

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Directed bench for eth_rx_frame_filter: two instances (type filter on/off)
// share one stimulus set, steered by sel, and are checked against a frame-level model.
module tb_eth_rx_frame_filter;
  import eth_pkg::*;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel;
  logic        hv;
  mac_addr_t   h_dst, h_src;
  logic [15:0] h_type;
  logic [7:0]  pd;
  logic        pv, pl, pu;
  logic        ohr, opr;
  mac_addr_t   cfg_mac;
  logic        cfg_mc;

  logic [1:0]  d_hr, d_pr, d_ohv, d_opv, d_opl, d_opu, d_opk, d_busy;
  mac_addr_t   d_odst [2];
  mac_addr_t   d_osrc [2];
  logic [15:0] d_otype [2];
  logic [7:0]  d_opd [2];
  logic [CW-1:0] d_pc [2];
  logic [CW-1:0] d_dc [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    eth_rx_frame_filter #(
      .DATA_WIDTH(8), .KEEP_ENABLE(0),
      .TYPE_FILTER_ENABLE((g == 0) ? 1 : 0), .CNT_WIDTH(CW)
    ) u_dut (
      .clk(clk), .reset(rst),
      .eth_header_in_valid(hv && (sel == (g == 1))),
      .eth_header_in_ready(d_hr[g]),
      .eth_header_in_dest_mac(h_dst), .eth_header_in_src_mac(h_src),
      .eth_header_in_eth_type(h_type),
      .eth_payload_in_tdata(pd), .eth_payload_in_tkeep(1'b1),
      .eth_payload_in_tvalid(pv && (sel == (g == 1))),
      .eth_payload_in_tready(d_pr[g]),
      .eth_payload_in_tlast(pl), .eth_payload_in_tuser(pu),
      .eth_header_out_valid(d_ohv[g]), .eth_header_out_ready(ohr),
      .eth_header_out_dest_mac(d_odst[g]), .eth_header_out_src_mac(d_osrc[g]),
      .eth_header_out_eth_type(d_otype[g]),
      .eth_payload_out_tdata(d_opd[g]), .eth_payload_out_tkeep(d_opk[g]),
      .eth_payload_out_tvalid(d_opv[g]), .eth_payload_out_tready(opr),
      .eth_payload_out_tlast(d_opl[g]), .eth_payload_out_tuser(d_opu[g]),
      .cfg_local_mac(cfg_mac), .cfg_mcast_enable(cfg_mc),
      .pass_count(d_pc[g]), .drop_count(d_dc[g]), .busy(d_busy[g])
    );
  end

  logic v_hr, v_pr, v_ohv, v_opv, v_opl, v_opu, v_busy;
  mac_addr_t v_odst, v_osrc;
  logic [15:0] v_otype;
  logic [7:0] v_opd;
  logic [CW-1:0] v_pc, v_dc;
  assign v_hr = d_hr[sel];     assign v_pr = d_pr[sel];
  assign v_ohv = d_ohv[sel];   assign v_opv = d_opv[sel];
  assign v_opl = d_opl[sel];   assign v_opu = d_opu[sel];
  assign v_busy = d_busy[sel];
  assign v_odst = d_odst[sel]; assign v_osrc = d_osrc[sel];
  assign v_otype = d_otype[sel]; assign v_opd = d_opd[sel];
  assign v_pc = d_pc[sel];     assign v_dc = d_dc[sel];

  int vec = 0;
  int err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: mode 0 = between frames, 1 = forwarding, 2 = discarding.
  int          mode = 0;
  bit          pend = 0;
  bit          seen = 0;
  mac_addr_t   e_dst, e_src;
  logic [15:0] e_type;
  int          mp [2] = '{0, 0};
  int          md [2] = '{0, 0};
  logic [7:0]  cap [$];

  always @(negedge clk) begin
    int  i;
    bit  e_hr, e_pr, tfe, mac_ok, type_ok;
    i = int'(sel);
    if (rst) begin
      mode = 0; pend = 0; seen = 0;
      mp[0] = 0; mp[1] = 0; md[0] = 0; md[1] = 0;
      chk("rst_hdr_in_ready", 64'(v_hr), 64'(0));
      chk("rst_pay_in_tready", 64'(v_pr), 64'(0));
      chk("rst_hdr_out_valid", 64'(v_ohv), 64'(0));
      chk("rst_hdr_out_dst", 64'(v_odst), 64'(0));
      chk("rst_pay_out_tvalid", 64'(v_opv), 64'(0));
      chk("rst_busy", 64'(v_busy), 64'(0));
      chk("rst_pass_count", 64'(v_pc), 64'(0));
      chk("rst_drop_count", 64'(v_dc), 64'(0));
    end else begin
      tfe  = (sel == 1'b0);
      e_hr = seen && (mode == 0) && !pend;
      e_pr = (mode == 0) ? 1'b0 : (mode == 2) ? 1'b1 : opr;
      chk("busy", 64'(v_busy), 64'(mode != 0));
      chk("hdr_in_ready", 64'(v_hr), 64'(e_hr));
      chk("hdr_out_valid", 64'(v_ohv), 64'(pend));
      chk("pass_count", 64'(v_pc), 64'(mp[i]));
      chk("drop_count", 64'(v_dc), 64'(md[i]));
      chk("pay_in_tready", 64'(v_pr), 64'(e_pr));
      chk("pay_out_tvalid", 64'(v_opv), 64'((mode == 1) && pv));
      if (mode == 1 && pv && opr) begin
        chk("pay_out_tdata", 64'(v_opd), 64'(pd));
        chk("pay_out_tlast", 64'(v_opl), 64'(pl));
        chk("pay_out_tuser", 64'(v_opu), 64'(pu));
        cap.push_back(v_opd);
      end
      if (pend && ohr) begin
        chk("hdr_out_dst", 64'(v_odst), 64'(e_dst));
        chk("hdr_out_src", 64'(v_osrc), 64'(e_src));
        chk("hdr_out_type", 64'(v_otype), 64'(e_type));
        pend = 0;
      end
      if (mode != 0 && pv && e_pr && pl) mode = 0;
      if (hv && e_hr) begin
        mac_ok  = (h_dst == cfg_mac) || (h_dst == 48'hFFFF_FFFF_FFFF) || (cfg_mc && h_dst[40]);
        type_ok = !tfe || (h_type == 16'h0800) || (h_type == 16'h0806);
        if (mac_ok && type_ok) begin
          pend = 1; e_dst = h_dst; e_src = h_src; e_type = h_type; mode = 1;
          if (mp[i] < CMAX) mp[i]++;
        end else begin
          mode = 2;
          if (md[i] < CMAX) md[i]++;
        end
      end
      seen = 1;
    end
  end

  task automatic send_hdr(input mac_addr_t d, input logic [15:0] t);
    bit ok;
    ok = 0;
    hv = 1; h_dst = d; h_src = 48'h0A0B_0C0D_0E0F; h_type = t;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); ok = v_hr;
      @(posedge clk); #1;
      if (ok) break;
    end
    hv = 0;
    chk("hdr_accept_within_bound", 64'(ok), 64'(1));
  endtask

  task automatic send_payload(input int n, input logic [7:0] base, input bit rnd,
                              input int abort_at, input bit bad);
    bit ok;
    for (int b = 0; b < n; b++) begin
      pv = 1; pd = base + 8'(b); pl = (b == n - 1); pu = bad && (b == n - 1);
      if (b == abort_at) return;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
        if (rnd) opr = 1'($urandom_range(0, 1));
        @(negedge clk); ok = v_pr;
        @(posedge clk); #1;
        if (ok) break;
      end
      if (!ok) begin
        chk("payload_beat_within_bound", 64'(ok), 64'(1));
        break;
      end
    end
    pv = 0; pl = 0; pu = 0; opr = 1;
  endtask

  initial begin
    #500000;
    err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1; sel = 0; hv = 0; h_dst = '0; h_src = '0; h_type = '0;
    pv = 0; pd = '0; pl = 0; pu = 0; ohr = 1; opr = 1;
    cfg_mac = 48'h0200_0000_0001; cfg_mc = 0;
    repeat (3) @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk); #1;

    // 1: unicast match, IPv4, 46 bytes
    cap.delete();
    send_hdr(48'h0200_0000_0001, 16'h0800);
    chk("t1_hdr_out_1cyc", 64'(v_ohv), 64'(1));
    chk("t1_hdr_out_dst", 64'(v_odst), 64'h0200_0000_0001);
    send_payload(46, 8'h10, 0, -1, 0);
    repeat (2) @(posedge clk); #1;
    chk("t1_bytes_out", 64'(cap.size()), 64'(46));
    if (cap.size() == 46) begin
      chk("t1_first_byte", 64'(cap[0]), 64'h10);
      chk("t1_last_byte", 64'(cap[45]), 64'h3D);
    end
    chk("t1_pass", 64'(v_pc), 64'(1));
    chk("t1_drop", 64'(v_dc), 64'(0));

    // 2: unicast mismatch, 60 bytes dropped at line rate
    cap.delete();
    send_hdr(48'h0200_0000_0099, 16'h0800);
    t0 = cyc;
    send_payload(60, 8'h40, 0, -1, 0);
    chk("t2_cycles", 64'(cyc - t0), 64'(60));
    chk("t2_busy_after_tlast", 64'(v_busy), 64'(0));
    chk("t2_bytes_out", 64'(cap.size()), 64'(0));
    chk("t2_drop", 64'(v_dc), 64'(1));

    // 3: broadcast and multicast, bad-frame flag still passes
    send_hdr(48'hFFFF_FFFF_FFFF, 16'h0806);
    send_payload(4, 8'h80, 0, -1, 1);
    send_hdr(48'h0100_5E00_0001, 16'h0800);
    send_payload(4, 8'h90, 0, -1, 0);
    cfg_mc = 1;
    send_hdr(48'h0100_5E00_0001, 16'h0800);
    send_payload(4, 8'hA0, 0, -1, 0);
    cfg_mc = 0;
    chk("t3_pass", 64'(v_pc), 64'(3));
    chk("t3_drop", 64'(v_dc), 64'(2));

    // 4: IPv6 EtherType with and without the type filter
    send_hdr(48'h0200_0000_0001, 16'h86DD);
    send_payload(4, 8'hB0, 0, -1, 0);
    chk("t4_filtered_drop", 64'(v_dc), 64'(3));
    repeat (2) @(posedge clk); #1;
    sel = 1;
    send_hdr(48'h0200_0000_0001, 16'h86DD);
    send_payload(4, 8'hB0, 0, -1, 0);
    repeat (2) @(posedge clk); #1;
    chk("t4_unfiltered_pass", 64'(d_pc[1]), 64'(1));
    chk("t4_unfiltered_drop", 64'(d_dc[1]), 64'(0));
    sel = 0;
    repeat (2) @(posedge clk); #1;

    // 5: downstream backpressure, header held until taken
    cap.delete();
    ohr = 0;
    send_hdr(48'h0200_0000_0001, 16'h0800);
    send_payload(30, 8'h20, 1, -1, 0);
    chk("t5_hdr_held", 64'(v_ohv), 64'(1));
    fork
      begin repeat (10) @(posedge clk); #1; ohr = 1; end
    join_none
    t0 = cyc;
    send_hdr(48'h0200_0000_0001, 16'h0806);
    chk("t5_next_hdr_waited", 64'((cyc - t0) > 10), 64'(1));
    chk("t5_bytes_out", 64'(cap.size()), 64'(30));
    for (int k = 0; k < 30 && k < cap.size(); k++)
      chk("t5_byte_order", 64'(cap[k]), 64'(8'h20 + 8'(k)));
    send_payload(5, 8'hC0, 0, -1, 0);
    chk("t5_pass", 64'(v_pc), 64'(5));

    // 6: reset on byte 20, then saturate the drop counter
    send_hdr(48'h0200_0000_0001, 16'h0800);
    send_payload(40, 8'h00, 0, 20, 0);
    rst = 1; #1;
    chk("t6_async_busy", 64'(v_busy), 64'(0));
    chk("t6_async_hdr_out", 64'(v_ohv), 64'(0));
    chk("t6_async_pay_out", 64'(v_opv), 64'(0));
    chk("t6_async_pay_ready", 64'(v_pr), 64'(0));
    chk("t6_async_pass", 64'(v_pc), 64'(0));
    repeat (2) @(posedge clk); #1;
    rst = 0;
    repeat (5) @(posedge clk); #1;
    chk("t6_leftover_stalls", 64'(v_pr), 64'(0));
    pv = 0; pl = 0;
    for (int f = 0; f < CMAX + 3; f++) begin
      send_hdr(48'h0200_0000_0099, 16'h0800);
      send_payload(1, 8'(f), 0, -1, 0);
    end
    repeat (2) @(posedge clk); #1;
    chk("t6_drop_saturated", 64'(v_dc), 64'(CMAX));
    chk("t6_pass_zero", 64'(v_pc), 64'(0));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
